// File: rtl/dmem_wait_responder_if.sv
// Data-access bus between the multicycle CPU and its memory responder.
// Single-word requests, completion signalled by a one-cycle ready pulse.
interface dmem_wait_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ready,
    input  err,
    input  busy
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ready,
    output err,
    output busy
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Slow data memory: holds each request for WAIT_CYCLES wait states,
// then commits and answers with a one-cycle ready (err on bad address).
module dmem_wait_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_wait_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  state_t      state;
  logic [7:0]  waitCnt;
  logic        latWe;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [31:0] rdataQ;
  logic        readyQ;
  logic        errQ;
  logic        busyQ;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] wordIdx;
  logic              misaligned;
  logic              outOfRange;
  logic              badAddr;
  logic              commit;
  logic              doWrite;

  assign wordIdx    = latAddr[ADDR_W+1:2];
  assign misaligned = |latAddr[1:0];
  assign outOfRange = |(latAddr >> (ADDR_W + 2));
  assign badAddr    = misaligned | outOfRange;

  // The access happens on the edge that leaves WAIT.
  assign commit  = (state == WAIT) && (waitCnt == 8'd0);
  assign doWrite = commit && latWe && !badAddr;

  assign bus.rdata = rdataQ;
  assign bus.ready = readyQ;
  assign bus.err   = errQ;
  assign bus.busy  = busyQ;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wordIdx] <= latWdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      waitCnt  <= 8'd0;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      rdataQ   <= '0;
      readyQ   <= 1'b0;
      errQ     <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            latWe    <= bus.we;
            latAddr  <= bus.addr;
            latWdata <= bus.wdata;
            waitCnt  <= WAIT_INIT;
            busyQ    <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt != 8'd0) begin
            waitCnt <= waitCnt - 8'd1;
          end else begin
            state  <= RESP;
            readyQ <= 1'b1;
            errQ   <= badAddr;
            rdataQ <= (latWe || badAddr) ? '0
                    : mem[wordIdx];
          end
        end
        RESP: begin
          state    <= IDLE;
          readyQ   <= 1'b0;
          errQ     <= 1'b0;
          busyQ    <= 1'b0;
          rdataQ   <= '0;
          latWe    <= 1'b0;
          latAddr  <= '0;
          latWdata <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance, directed requests, queued expectations checked by a monitor.
module tb_dmem_wait_responder;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  reqV;
  logic [1:0]  weV;
  logic [31:0] addrV  [2];
  logic [31:0] wdataV [2];

  int   cyc;
  int   asserts;
  int   fails;
  exp_t q0[$];
  exp_t q1[$];

  dmem_wait_responder_if bus2 ();
  dmem_wait_responder_if bus0 ();

  assign bus2.req   = reqV[0];
  assign bus2.we    = weV[0];
  assign bus2.addr  = addrV[0];
  assign bus2.wdata = wdataV[0];
  assign bus0.req   = reqV[1];
  assign bus0.we    = weV[1];
  assign bus0.addr  = addrV[1];
  assign bus0.wdata = wdataV[1];

  dmem_wait_responder #(
    .ADDR_W      (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dmem_wait_responder #(
    .ADDR_W      (8),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic busyOf(input int s);
    return (s == 0) ? bus2.busy : bus0.busy;
  endfunction

  task automatic pushExp(input int s, input exp_t x);
    if (s == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic mon(input int s,
                     input logic rdy,
                     input logic b,
                     input logic e,
                     input logic [31:0] rd);
    exp_t x;
    if (!rdy) return;
    if (qsize(s) == 0) begin
      asserts++;
      fails++;
      $display("FAIL spurious_ready dut%0d: ready=1 required=0", s);
      return;
    end
    if (s == 0) x = q0.pop_front();
    else x = q1.pop_front();
    check($sformatf("rdata dut%0d", s), rd, x.rd);
    check($sformatf("err dut%0d", s), 32'(e), 32'(x.e));
    check($sformatf("latency dut%0d", s), 32'(cyc), 32'(x.cyc));
    check($sformatf("busy_resp dut%0d", s), 32'(b), 32'd1);
  endtask

  always @(negedge clk) begin
    mon(0, bus2.ready, bus2.busy, bus2.err, bus2.rdata);
    mon(1, bus0.ready, bus0.busy, bus0.err, bus0.rdata);
  end

  task automatic waitDone(input int s);
    int n;
    n = 0;
    while (qsize(s) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (qsize(s) != 0) begin
      asserts++;
      fails++;
      $display("FAIL timeout dut%0d: pending=%0d required=0", s, qsize(s));
      if (s == 0) q0.delete();
      else q1.delete();
    end
    @(negedge clk);
  endtask

  // s=0 targets the 2-wait-state instance, s=1 the zero-wait one.
  task automatic doReq(input int s,
                       input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [31:0] d2,
                       input logic [31:0] er,
                       input logic ee);
    exp_t x;
    @(negedge clk);
    reqV[s]   = 1'b1;
    weV[s]    = w;
    addrV[s]  = a;
    wdataV[s] = d;
    x.rd  = er;
    x.e   = ee;
    x.cyc = cyc + ((s == 0) ? 4 : 2);
    pushExp(s, x);
    @(negedge clk);
    check($sformatf("busy_wait dut%0d", s), 32'(busyOf(s)), 32'd1);
    reqV[s]   = 1'b0;
    weV[s]    = ~w;
    addrV[s]  = a ^ 32'h4;
    wdataV[s] = d2;
    waitDone(s);
  endtask

  initial begin
    int   c;
    exp_t x;
    asserts = 0;
    fails   = 0;
    reset   = 1'b1;
    reqV    = '0;
    weV     = '0;
    for (int i = 0; i < 2; i++) begin
      addrV[i]  = '0;
      wdataV[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus2.ready), 32'd0);
    check("rst_busy", 32'(bus2.busy), 32'd0);
    check("rst_err", 32'(bus2.err), 32'd0);
    check("rst_rdata", bus2.rdata, 32'd0);
    check("rst_busy0", 32'(bus0.busy), 32'd0);
    reset = 1'b0;

    doReq(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0, 0);
    doReq(0, 0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 0);

    doReq(1, 1, 32'h0, 32'h12345678, 32'h0, 32'h0, 0);
    doReq(1, 0, 32'h0, 32'h0, 32'h0, 32'h12345678, 0);
    doReq(1, 0, 32'h2, 32'h0, 32'h0, 32'h0, 1);

    doReq(0, 1, 32'h12, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
    doReq(0, 0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    doReq(0, 0, 32'h400, 32'h0, 32'h0, 32'h0, 1);
    doReq(0, 1, 32'h1000_0010, 32'h77777777, 32'h0, 32'h0, 1);
    doReq(0, 0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    doReq(0, 1, 32'h3FC, 32'h0BADCAFE, 32'h0, 32'h0, 0);
    doReq(0, 0, 32'h3FC, 32'h0, 32'h0, 32'h0BADCAFE, 0);

    // Held req with a changed address is only taken after RESP.
    doReq(0, 1, 32'h20, 32'h20202020, 32'h0, 32'h0, 0);
    @(negedge clk);
    c = cyc;
    reqV[0]  = 1'b1;
    weV[0]   = 1'b0;
    addrV[0] = 32'h10;
    x.rd = 32'hDEADBEEF; x.e = 1'b0; x.cyc = c + 4;
    pushExp(0, x);
    x.rd = 32'h20202020; x.e = 1'b0; x.cyc = c + 9;
    pushExp(0, x);
    @(negedge clk);
    addrV[0] = 32'h20;
    while (cyc < c + 6) @(negedge clk);
    reqV[0] = 1'b0;
    waitDone(0);

    doReq(0, 1, 32'h30, 32'h11111111, 32'h0, 32'h0, 0);
    @(negedge clk);
    reqV[0]   = 1'b1;
    weV[0]    = 1'b1;
    addrV[0]  = 32'h30;
    wdataV[0] = 32'hCAFEF00D;
    @(negedge clk);
    reqV[0] = 1'b0;
    reset   = 1'b1;
    #1;
    check("abort_ready", 32'(bus2.ready), 32'd0);
    check("abort_busy", 32'(bus2.busy), 32'd0);
    check("abort_err", 32'(bus2.err), 32'd0);
    check("abort_rdata", bus2.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    doReq(0, 0, 32'h30, 32'h0, 32'h0, 32'h11111111, 0);

    doReq(0, 1, 32'h40, 32'hAAAA0000, 32'h5555FFFF, 32'h0, 0);
    doReq(0, 0, 32'h40, 32'h0, 32'h0, 32'hAAAA0000, 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Memory-side responder for the multicycle CPU data-access port.
- Accepts single-word read/write requests over a req/ready handshake and holds them for a programmable number of wait states before committing.
- Returns read data, or flags an error, with a one-cycle ready pulse.
- Replaces the zero-latency data memory so the CPU controller can be exercised against a slow memory.

Parameters:
- ADDR_W, 8, word-address width; storage depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra cycles spent in WAIT before the access commits (0..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  byte address; addr[ADDR_W+1:2] selects the word.
- wdata  input  32  write data; sampled with req.
- rdata  output  32  read data; valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- err  output  1  qualifies ready; 1 = request rejected.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, rdata=0, ready=0, err=0, busy=0, latched request fields cleared. Storage array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE, req=1 at edge E0:
  - latch we, addr, wdata;
  - load counter with WAIT_CYCLES;
  - go to WAIT; busy=1 from E0.
- IDLE, req=0: stay in IDLE.
- WAIT:
  - counter != 0: decrement and stay.
  - counter == 0: at the next edge, perform the access and go to RESP.
- Latency: ready=1 in the cycle following edge E0+WAIT_CYCLES+1. With WAIT_CYCLES=0, ready rises after E1.
- Access at the WAIT→RESP edge:
  - read: rdata <= mem[word].
  - write: mem[word] <= wdata; rdata <= 0.
- RESP:
  - ready=1 for exactly one cycle, busy=1.
  - next edge: IDLE, ready=0, busy=0, rdata=0, err=0.
- Error checks, evaluated on the latched address:
  - misaligned: addr[1:0] != 0;
  - out of range: addr[31:ADDR_W+2] != 0.
  - Either condition sets err=1 with ready in RESP, suppresses the write, and forces rdata=0. Wait states still elapse, so latency is unchanged.
- req while busy: ignored and not queued. The requester must hold req until ready, or re-issue.
- Back-to-back: req=1 in the RESP cycle is ignored; the earliest next acceptance is the IDLE cycle after RESP. Minimum request spacing is WAIT_CYCLES+3 cycles.
- Input changes after acceptance (we/addr/wdata) have no effect; only latched values are used.
- Reset mid-operation:
  - during WAIT: the request is aborted, no write occurs, no ready pulse.
  - during RESP: the write has already committed and remains; the ready pulse is truncated.
- Read-after-write to the same word returns the newly written data.
- Counter width is 8 bits; WAIT_CYCLES > 255 is illegal.

Test Plan:
- Write then read, WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, req pulse at E0 → ready=1, err=0 after E3. Read at addr 0x10 → rdata=0xDEADBEEF with ready after E3 of that request; busy high throughout each request.
- WAIT_CYCLES=0: read addr 0x0 after a prior write of 0x12345678 → ready after E1 (latency 2 edges), rdata=0x12345678.
- Errors: write addr=0x12 (misaligned), wdata=0xFFFFFFFF → ready with err=1, rdata=0. Subsequent read of 0x10 still returns the old value. Read addr=0x400 (out of range, ADDR_W=8) → err=1, rdata=0.
- Busy rejection: issue a read of 0x10, hold req=1 and change addr to 0x20 during WAIT → exactly one ready pulse, with data from 0x10. The second request is accepted only after return to IDLE, giving a second ready pulse WAIT_CYCLES+3 cycles after the first.
- Reset during WAIT: write 0xCAFEF00D to 0x30 and assert reset one cycle after acceptance → ready never rises, outputs go to 0 immediately. A subsequent read of 0x30 returns the prior contents, not 0xCAFEF00D.
- Stable inputs: change wdata from 0xAAAA0000 to 0x5555FFFF during WAIT → memory holds 0xAAAA0000.
